// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: state encodings,
// opcodes, immediate formats and ALU operation codes.
package multicycle_controller_pkg;

    localparam int STATE_W = 4;
    localparam int OP_W    = 7;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [OP_W-1:0] OP_LW    = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW    = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the FSM's aluop plus instruction function fields onto an ALU operation.
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op5=1) can encode sub; addi with imm[10]=1 stays add.
                    3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch through
// writeback over one ALU and one unified memory port.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    input  logic               mem_ready,
    output logic [1:0]         immsrc,
    output logic [1:0]         alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         resultsrc,
    output logic               adrsrc,
    output logic [2:0]         alucontrol,
    output logic               irwrite,
    output logic               pcwrite,
    output logic               regwrite,
    output logic               memwrite,
    output logic               illegal,
    output logic [STATE_W-1:0] state_o
);

    state_t     state_q, state_d;
    logic [1:0] aluop;
    logic       irwrite_c, pcwrite_c, regwrite_c, memwrite_c, illegal_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        adrsrc     = 1'b0;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        resultsrc  = 2'b00;
        aluop      = ALUOP_ADD;
        irwrite_c  = 1'b0;
        pcwrite_c  = 1'b0;
        regwrite_c = 1'b0;
        memwrite_c = 1'b0;
        illegal_c  = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite_c = mem_ready;
                pcwrite_c = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECR;
                    OP_ITYPE:     state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrsrc = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc  = 2'b01;
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adrsrc     = 1'b1;
                memwrite_c = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                alusrca = 2'b10;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXECI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_JAL: begin
                alusrca   = 2'b01;
                alusrcb   = 2'b10;
                pcwrite_c = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                alusrca   = 2'b10;
                aluop     = ALUOP_SUB;
                pcwrite_c = zero;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   immsrc = IMM_S;
            OP_BEQ:  immsrc = IMM_B;
            OP_JAL:  immsrc = IMM_J;
            default: immsrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .alucontrol (alucontrol)
    );

    // Strobes are gated by rst_n so nothing fires between the reset edge and the next clock.
    assign irwrite  = rst_n & irwrite_c;
    assign pcwrite  = rst_n & pcwrite_c;
    assign regwrite = rst_n & regwrite_c;
    assign memwrite = rst_n & memwrite_c;
    assign illegal  = rst_n & illegal_c;
    assign state_o  = state_q;

endmodule
